id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register directly upstream of the ALU.
- Latches decoded operands and control from ID and drives the ALU operand and control inputs: rdata1, rdata2, imm, pc_in, alu_ctrl, alu_immsrc, alu_pcsrc.
- Resolves RAW hazards by forwarding from MEM and WB, detects load-use hazards, and inserts bubbles on branch flush.

Parameters:
- XLEN, 32, datapath width
- CTRL_W, 5, ALU control width (matches ALU_CTRL_BITS)
- RA_W, 5, register address width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- id_valid  in  1  ID holds a real instruction
- id_pc  in  XLEN  PC of the ID instruction
- id_rs1, id_rs2, id_rd  in  RA_W  register addresses
- id_use_rs1, id_use_rs2  in  1  instruction reads rs1/rs2
- id_rdata1, id_rdata2, id_imm  in  XLEN  register-file reads and immediate
- id_alu_ctrl  in  CTRL_W  ALU operation
- id_alu_immsrc, id_alu_pcsrc  in  1  ALU source selects
- id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg  in  1  downstream control
- mem_rd  in  RA_W  destination register of the MEM-stage instruction
- mem_reg_write  in  1  MEM-stage instruction writes a register
- mem_fwd_data  in  XLEN  forwardable result from MEM
- wb_rd  in  RA_W  destination register of the WB-stage instruction
- wb_reg_write  in  1  WB-stage instruction writes a register
- wb_data  in  XLEN  write-back data
- ex_branch_taken  in  1  redirect from EX (branch/jump resolved taken)
- stall_ext  in  1  global hold (e.g. D-cache miss)
- ex_valid  out  1  EX holds a real instruction
- ex_pc, ex_rdata1, ex_rdata2, ex_imm  out  XLEN  to ALU (pc_in, rdata1, rdata2, imm)
- ex_alu_ctrl  out  CTRL_W  to ALU
- ex_alu_immsrc, ex_alu_pcsrc  out  1  to ALU
- ex_rd  out  RA_W  EX destination register
- ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg  out  1  to EX/MEM
- id_stall  out  1  hold PC and IF/ID; insert bubble

Behaviour:
- Reset (rst_n low, asynchronous): every registered field is 0, so ex_valid=0 and all ex_* outputs are 0. id_stall=0 while in reset.
- Register priority on each rising edge, highest first:
  1. stall_ext=1: hold the stage. The stored rdata1/rdata2 are overwritten with their forwarded values (operand refresh), so a producer that retires during the hold is not lost.
  2. ex_branch_taken=1 or id_stall=1: load a bubble. ex_valid=0; mem_read, mem_write and reg_write are 0; alu_ctrl=0; other fields are don't-care but driven to 0.
  3. Otherwise capture all ID fields. ex_valid=id_valid.
- Capture bypass: if wb_reg_write=1, wb_rd!=0 and wb_rd==id_rsN, capture wb_data instead of id_rdataN. This covers register-file read-before-write.
- Forwarding (combinational, on ex_rdataN outputs):
  - If the stored rsN is 0, output the stored value; x0 is never forwarded.
  - Else if mem_reg_write=1 and mem_rd==rsN, output mem_fwd_data. MEM has priority over WB.
  - Else if wb_reg_write=1 and wb_rd==rsN, output wb_data.
  - Otherwise output the stored value.
  - The stored rs1/rs2 and use bits are internal registers.
- Load-use: id_stall = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). The hazard lasts exactly 1 bubble cycle.
- ex_branch_taken=1 forces id_stall=0; the redirect dominates.
- Latency: 1 cycle from ID to ALU inputs. Forwarding adds no cycles.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: MEM/WB forwarding and operand refresh as above.
- Undefined:
  - Outputs are the stored values only; no forwarding.
  - id_stall additionally asserts on any match of id_rs1/id_rs2 (when used, !=0) with ex_rd&ex_reg_write&ex_valid or with mem_rd&mem_reg_write.
  - The WB capture bypass is kept.

Decomposition:
- Shared header pipe_def.v: XLEN, RA_W, the bubble control encoding, and an include of alu_control_def.v for CTRL_W and ALUCTRL_* codes.
- One natural sub-module, id_ex_fwd_mux: per-operand MEM/WB/stored select with the x0 guard, instantiated twice.

Test Plan:
- Reset: drive rst_n=0 mid-run with id_valid=1 -> all ex_* outputs are 0 immediately; the first post-reset edge captures ID.
- EX->EX forward: hold x5=0x10; mem_reg_write=1, mem_rd=5, mem_fwd_data=0x1234, wb_rd=5, wb_data=0x99 -> ex_rdata1=0x1234. With mem_rd=0 -> ex_rdata1=0x99 when wb_rd=5, else the stored value.
- Load-use: EX holds lw x7 (mem_read=1); ID holds add rs2=7 with id_use_rs2=1 -> id_stall=1 for one cycle, then ex_valid=0 bubble, then the add is captured with ex_valid=1.
- Flush with hazard: ex_branch_taken=1 while the load-use condition holds -> id_stall=0 and the next cycle has ex_valid=0, ex_reg_write=0.
- Stall refresh: stall_ext=1 for 3 cycles while wb writes x3=0xABCD once (rs1=3) -> after release, ex_rdata1=0xABCD with no MEM/WB match.
- x0 guard: rs1=0, mem_reg_write=1, mem_rd=0, mem_fwd_data=0xFFFF -> ex_rdata1 equals the stored 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: default widths,
// ALU control codes and the bubble control encoding.
package id_ex_stage_pkg;

    localparam int unsigned DEF_XLEN      = 32;
    localparam int unsigned DEF_RA_W      = 5;
    localparam int unsigned ALU_CTRL_BITS = 5;

    typedef enum logic [ALU_CTRL_BITS-1:0] {
        ALUCTRL_ADD  = 5'd0,
        ALUCTRL_SUB  = 5'd1,
        ALUCTRL_AND  = 5'd2,
        ALUCTRL_OR   = 5'd3,
        ALUCTRL_XOR  = 5'd4,
        ALUCTRL_SLL  = 5'd5,
        ALUCTRL_SRL  = 5'd6,
        ALUCTRL_SRA  = 5'd7,
        ALUCTRL_SLT  = 5'd8,
        ALUCTRL_SLTU = 5'd9,
        ALUCTRL_LUI  = 5'd10
    } alu_ctrl_e;

    // Downstream (EX/MEM/WB) control carried through the stage
    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic mem_to_reg;
    } mem_ctrl_t;

    // A bubble performs no memory access and no register write
    localparam mem_ctrl_t BUBBLE_CTRL     = '0;
    localparam alu_ctrl_e BUBBLE_ALU_CTRL = ALUCTRL_ADD;

endpackage

// File: rtl/id_ex_fwd_mux.sv
// Per-operand forwarding select: MEM result, then WB data, then the
// stored operand. Register x0 is never forwarded.
module id_ex_fwd_mux
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN = DEF_XLEN,
    parameter int unsigned RA_W = DEF_RA_W
) (
    input  logic [RA_W-1:0] rs,
    input  logic [XLEN-1:0] stored,
    input  logic [RA_W-1:0] mem_rd,
    input  logic            mem_reg_write,
    input  logic [XLEN-1:0] mem_data,
    input  logic [RA_W-1:0] wb_rd,
    input  logic            wb_reg_write,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] fwd
);

    // Youngest producer wins; x0 always reads the stored value
    always_comb begin
        fwd = stored;
        if (rs != '0) begin
            if (mem_reg_write && (mem_rd == rs)) begin
                fwd = mem_data;
            end else if (wb_reg_write && (wb_rd == rs)) begin
                fwd = wb_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU. Handles WB capture bypass,
// load-use hazard detection and branch-flush bubbles.
// Optional macro ID_EX_FWD_EN: MEM/WB forwarding on the operand outputs
// plus operand refresh during an external hold. Without it, outputs are the
// stored operands and any pending EX/MEM producer stalls ID instead.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int unsigned XLEN   = DEF_XLEN,
    parameter int unsigned CTRL_W = ALU_CTRL_BITS,
    parameter int unsigned RA_W   = DEF_RA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic [RA_W-1:0]   id_rd,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [XLEN-1:0]   id_rdata1,
    input  logic [XLEN-1:0]   id_rdata2,
    input  logic [XLEN-1:0]   id_imm,
    input  logic [CTRL_W-1:0] id_alu_ctrl,
    input  logic              id_alu_immsrc,
    input  logic              id_alu_pcsrc,
    input  logic              id_mem_read,
    input  logic              id_mem_write,
    input  logic              id_reg_write,
    input  logic              id_mem_to_reg,
    input  logic [RA_W-1:0]   mem_rd,
    input  logic              mem_reg_write,
    input  logic [XLEN-1:0]   mem_fwd_data,
    input  logic [RA_W-1:0]   wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_data,
    input  logic              ex_branch_taken,
    input  logic              stall_ext,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_rdata1,
    output logic [XLEN-1:0]   ex_rdata2,
    output logic [XLEN-1:0]   ex_imm,
    output logic [CTRL_W-1:0] ex_alu_ctrl,
    output logic              ex_alu_immsrc,
    output logic              ex_alu_pcsrc,
    output logic [RA_W-1:0]   ex_rd,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              ex_reg_write,
    output logic              ex_mem_to_reg,
    output logic              id_stall
);

    logic [XLEN-1:0] rdata1_q, rdata2_q;
    logic [XLEN-1:0] cap_rdata1, cap_rdata2;
    mem_ctrl_t       ctrl_q;
    logic            load_use;
    logic            raw_hold;

    assign ex_mem_read   = ctrl_q.mem_read;
    assign ex_mem_write  = ctrl_q.mem_write;
    assign ex_reg_write  = ctrl_q.reg_write;
    assign ex_mem_to_reg = ctrl_q.mem_to_reg;

`ifdef ID_EX_FWD_EN
    logic [RA_W-1:0] rs1_q, rs2_q;
    logic [XLEN-1:0] fwd_rdata1, fwd_rdata2;

    id_ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd1 (
        .rs(rs1_q), .stored(rdata1_q),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_data(mem_fwd_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .fwd(fwd_rdata1)
    );

    id_ex_fwd_mux #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd2 (
        .rs(rs2_q), .stored(rdata2_q),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_data(mem_fwd_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .fwd(fwd_rdata2)
    );

    assign ex_rdata1 = fwd_rdata1;
    assign ex_rdata2 = fwd_rdata2;
`else
    logic unused_fwd_data;

    assign unused_fwd_data = ^mem_fwd_data;
    assign ex_rdata1       = rdata1_q;
    assign ex_rdata2       = rdata2_q;
`endif

    // Register-file read-before-write: take the WB value being written now
    always_comb begin
        cap_rdata1 = id_rdata1;
        cap_rdata2 = id_rdata2;
        if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs1)) cap_rdata1 = wb_data;
        if (wb_reg_write && (wb_rd != '0) && (wb_rd == id_rs2)) cap_rdata2 = wb_data;
    end

    // Hazard detection; a taken redirect squashes ID anyway, so never stall
    always_comb begin
        load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid &&
                   ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                    (id_use_rs2 && (id_rs2 == ex_rd)));
        raw_hold = 1'b0;
`ifndef ID_EX_FWD_EN
        raw_hold = id_valid && (
            (id_use_rs1 && (id_rs1 != '0) &&
             ((ex_valid && ex_reg_write && (id_rs1 == ex_rd)) ||
              (mem_reg_write && (id_rs1 == mem_rd)))) ||
            (id_use_rs2 && (id_rs2 != '0) &&
             ((ex_valid && ex_reg_write && (id_rs2 == ex_rd)) ||
              (mem_reg_write && (id_rs2 == mem_rd)))));
`endif
        id_stall = !ex_branch_taken && (load_use || raw_hold);
    end

    // Stage register: external hold, then bubble, then capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            rdata1_q      <= '0;
            rdata2_q      <= '0;
            ex_imm        <= '0;
            ex_alu_ctrl   <= '0;
            ex_alu_immsrc <= 1'b0;
            ex_alu_pcsrc  <= 1'b0;
            ex_rd         <= '0;
            ctrl_q        <= BUBBLE_CTRL;
`ifdef ID_EX_FWD_EN
            rs1_q         <= '0;
            rs2_q         <= '0;
`endif
        end else if (stall_ext) begin
`ifdef ID_EX_FWD_EN
            // Latch forwarded operands so a producer retiring during the hold is kept
            rdata1_q <= fwd_rdata1;
            rdata2_q <= fwd_rdata2;
`endif
        end else if (ex_branch_taken || id_stall) begin
            ex_valid      <= 1'b0;
            ex_pc         <= '0;
            rdata1_q      <= '0;
            rdata2_q      <= '0;
            ex_imm        <= '0;
            ex_alu_ctrl   <= CTRL_W'(BUBBLE_ALU_CTRL);
            ex_alu_immsrc <= 1'b0;
            ex_alu_pcsrc  <= 1'b0;
            ex_rd         <= '0;
            ctrl_q        <= BUBBLE_CTRL;
`ifdef ID_EX_FWD_EN
            rs1_q         <= '0;
            rs2_q         <= '0;
`endif
        end else begin
            ex_valid      <= id_valid;
            ex_pc         <= id_pc;
            rdata1_q      <= cap_rdata1;
            rdata2_q      <= cap_rdata2;
            ex_imm        <= id_imm;
            ex_alu_ctrl   <= id_alu_ctrl;
            ex_alu_immsrc <= id_alu_immsrc;
            ex_alu_pcsrc  <= id_alu_pcsrc;
            ex_rd         <= id_rd;
            ctrl_q        <= '{mem_read: id_mem_read, mem_write: id_mem_write,
                               reg_write: id_reg_write, mem_to_reg: id_mem_to_reg};
`ifdef ID_EX_FWD_EN
            rs1_q         <= id_rs1;
            rs2_q         <= id_rs2;
`endif
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for single-cycle behaviour
// plus hand-written sequences for forwarding, refresh, flush and reset.
module tb_id_ex_stage;

`ifdef ID_EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    localparam int K_CAP = 0;
    localparam int K_BUB = 1;
    localparam int K_HLD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2;
    logic [31:0] id_rdata1, id_rdata2, id_imm;
    logic [4:0]  id_alu_ctrl;
    logic        id_alu_immsrc, id_alu_pcsrc;
    logic        id_mem_read, id_mem_write, id_reg_write, id_mem_to_reg;
    logic [4:0]  mem_rd;
    logic        mem_reg_write;
    logic [31:0] mem_fwd_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        ex_branch_taken, stall_ext;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rdata1, ex_rdata2, ex_imm;
    logic [4:0]  ex_alu_ctrl;
    logic        ex_alu_immsrc, ex_alu_pcsrc;
    logic [4:0]  ex_rd;
    logic        ex_mem_read, ex_mem_write, ex_reg_write, ex_mem_to_reg;
    logic        id_stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32), .CTRL_W(5), .RA_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm),
        .id_alu_ctrl(id_alu_ctrl), .id_alu_immsrc(id_alu_immsrc), .id_alu_pcsrc(id_alu_pcsrc),
        .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_reg_write(id_reg_write), .id_mem_to_reg(id_mem_to_reg),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_fwd_data(mem_fwd_data),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
        .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2),
        .ex_imm(ex_imm), .ex_alu_ctrl(ex_alu_ctrl),
        .ex_alu_immsrc(ex_alu_immsrc), .ex_alu_pcsrc(ex_alu_pcsrc),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .id_stall(id_stall)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [31:0] d1, d2;
        logic        mr, rw;
        logic [4:0]  wbrd;
        logic        wbrw;
        logic [31:0] wbd;
        logic        br, stx;
        logic        e_stall;
        int          kind;
        logic        e_valid;
        logic [31:0] e_d1, e_d2;
        logic [4:0]  e_rd;
        logic        e_mr, e_rw;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic u1, input logic u2,
                           input logic [31:0] d1, input logic [31:0] d2,
                           input logic mr, input logic rw,
                           input logic [4:0] wbrd, input logic wbrw, input logic [31:0] wbd,
                           input logic br, input logic stx, input logic es, input int kind,
                           input logic ev, input logic [31:0] ed1, input logic [31:0] ed2,
                           input logic [4:0] erd, input logic emr, input logic erw);
        vec_t t;
        t.v = v; t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2;
        t.d1 = d1; t.d2 = d2; t.mr = mr; t.rw = rw;
        t.wbrd = wbrd; t.wbrw = wbrw; t.wbd = wbd; t.br = br; t.stx = stx;
        t.e_stall = es; t.kind = kind; t.e_valid = ev; t.e_d1 = ed1; t.e_d2 = ed2;
        t.e_rd = erd; t.e_mr = emr; t.e_rw = erw;
        tbl.push_back(t);
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic u1, input logic u2,
                            input logic [31:0] d1, input logic [31:0] d2,
                            input logic mr, input logic rw);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_rdata1 = d1; id_rdata2 = d2;
        id_mem_read = mr; id_reg_write = rw; id_mem_to_reg = mr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] e_pc, e_imm;
        logic [4:0]  e_ctrl;
        logic        e_isrc, e_psrc, e_mw, e_m2r;

        rst_n = 1'b0;
        drive_id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        id_pc = '0; id_imm = '0; id_alu_ctrl = '0; id_alu_immsrc = 0; id_alu_pcsrc = 0;
        id_mem_write = 0;
        mem_rd = '0; mem_reg_write = 0; mem_fwd_data = '0;
        wb_rd = '0; wb_reg_write = 0; wb_data = '0;
        ex_branch_taken = 0; stall_ext = 0;

        #2;
        chk("reset ex_valid", ex_valid, 0);
        chk("reset ex_pc", ex_pc, 0);
        chk("reset ex_alu_ctrl", ex_alu_ctrl, 0);
        chk("reset id_stall", id_stall, 0);
        #10;
        rst_n = 1'b1;

        //       v rs1 rs2 rd u1 u2 d1        d2        mr rw wbrd wbrw wbd         br stx es kind   ev e_d1      e_d2       erd mr rw
        add_vec(1, 1,  2,  3, 1, 1, 32'h11,   32'h22,   0, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h11,   32'h22,    3, 0, 1);
        add_vec(1, 4,  5,  6, 1, 1, 32'h44,   32'h55,   0, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h44,   32'h55,    6, 0, 1);
        add_vec(1, 7,  8,  9, 1, 1, 32'h70,   32'h80,   0, 1, 8,  1,  32'hBEEF,   0, 0,  0, K_CAP, 1, 32'h70,   32'hBEEF,  9, 0, 1);
        add_vec(1, 0, 10, 11, 1, 1, 32'h5,    32'hA0,   0, 1, 0,  1,  32'hDEAD,   0, 0,  0, K_CAP, 1, 32'h5,    32'hA0,   11, 0, 1);
        add_vec(1, 12, 0,  7, 1, 0, 32'h1000, 32'h0,    1, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h1000, 32'h0,     7, 1, 1);
        add_vec(1, 13, 7, 14, 1, 1, 32'h130,  32'h777,  0, 1, 0,  0,  0,          0, 0,  1, K_BUB, 0, 32'h0,    32'h0,     0, 0, 0);
        add_vec(1, 13, 7, 14, 1, 1, 32'h130,  32'h777,  0, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h130,  32'h777,  14, 0, 1);
        add_vec(1, 1,  0, 15, 1, 0, 32'h1,    32'h0,    1, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h1,    32'h0,    15, 1, 1);
        add_vec(1, 16, 15, 17, 1, 0, 32'h160, 32'h150,  0, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h160,  32'h150,  17, 0, 1);
        add_vec(1, 2,  0,  0, 1, 0, 32'h2,    32'h0,    1, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h2,    32'h0,     0, 1, 1);
        add_vec(1, 0,  3, 18, 1, 1, 32'h0,    32'h33,   0, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h0,    32'h33,   18, 0, 1);
        add_vec(1, 1,  0, 20, 1, 0, 32'h1,    32'h0,    1, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h1,    32'h0,    20, 1, 1);
        add_vec(0, 20, 0, 21, 1, 0, 32'h200,  32'h0,    0, 1, 0,  0,  0,          0, 0,  0, K_CAP, 0, 32'h200,  32'h0,    21, 0, 1);
        add_vec(1, 1,  0, 22, 1, 0, 32'h1,    32'h0,    1, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h1,    32'h0,    22, 1, 1);
        add_vec(1, 22, 0, 23, 1, 0, 32'h220,  32'h0,    0, 1, 0,  0,  0,          1, 0,  0, K_BUB, 0, 32'h0,    32'h0,     0, 0, 0);
        add_vec(1, 23, 0, 24, 1, 0, 32'h2300, 32'h0,    0, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h2300, 32'h0,    24, 0, 1);
        add_vec(1, 25, 0, 26, 1, 0, 32'h9999, 32'h0,    0, 1, 0,  0,  0,          0, 1,  0, K_HLD, 1, 32'h2300, 32'h0,    24, 0, 1);
        add_vec(1, 25, 0, 26, 1, 0, 32'h9999, 32'h0,    0, 1, 0,  0,  0,          1, 1,  0, K_HLD, 1, 32'h2300, 32'h0,    24, 0, 1);
        add_vec(1, 25, 0, 26, 1, 0, 32'h9999, 32'h0,    0, 1, 0,  0,  0,          0, 0,  0, K_CAP, 1, 32'h9999, 32'h0,    26, 0, 1);

        e_pc = '0; e_imm = '0; e_ctrl = '0; e_isrc = 0; e_psrc = 0; e_mw = 0; e_m2r = 0;
        for (int i = 0; i < tbl.size(); i++) begin
            drive_id(tbl[i].v, tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].u1, tbl[i].u2,
                     tbl[i].d1, tbl[i].d2, tbl[i].mr, tbl[i].rw);
            id_pc         = 32'h1000 + 32'(i) * 4;
            id_imm        = 32'(i) * 3 + 1;
            id_alu_ctrl   = 5'(i + 1);
            id_alu_immsrc = 1'(i & 1);
            id_alu_pcsrc  = 1'((i >> 1) & 1);
            id_mem_write  = 1'((i >> 2) & 1);
            mem_rd = '0; mem_reg_write = 0;
            wb_rd = tbl[i].wbrd; wb_reg_write = tbl[i].wbrw; wb_data = tbl[i].wbd;
            ex_branch_taken = tbl[i].br; stall_ext = tbl[i].stx;
            #1;
            chk($sformatf("v%0d id_stall", i), id_stall, tbl[i].e_stall);
            tick();
            wb_reg_write = 0; ex_branch_taken = 0; stall_ext = 0;
            #1;
            if (tbl[i].kind == K_CAP) begin
                e_pc = 32'h1000 + 32'(i) * 4; e_imm = 32'(i) * 3 + 1; e_ctrl = 5'(i + 1);
                e_isrc = 1'(i & 1); e_psrc = 1'((i >> 1) & 1); e_mw = 1'((i >> 2) & 1);
                e_m2r = tbl[i].mr;
            end else if (tbl[i].kind == K_BUB) begin
                e_pc = '0; e_imm = '0; e_ctrl = '0; e_isrc = 0; e_psrc = 0; e_mw = 0; e_m2r = 0;
            end
            chk($sformatf("v%0d ex_valid", i), ex_valid, tbl[i].e_valid);
            chk($sformatf("v%0d ex_rdata1", i), ex_rdata1, tbl[i].e_d1);
            chk($sformatf("v%0d ex_rdata2", i), ex_rdata2, tbl[i].e_d2);
            chk($sformatf("v%0d ex_rd", i), ex_rd, tbl[i].e_rd);
            chk($sformatf("v%0d ex_mem_read", i), ex_mem_read, tbl[i].e_mr);
            chk($sformatf("v%0d ex_reg_write", i), ex_reg_write, tbl[i].e_rw);
            chk($sformatf("v%0d ex_pc", i), ex_pc, e_pc);
            chk($sformatf("v%0d ex_imm", i), ex_imm, e_imm);
            chk($sformatf("v%0d ex_alu_ctrl", i), ex_alu_ctrl, e_ctrl);
            chk($sformatf("v%0d ex_alu_immsrc", i), ex_alu_immsrc, e_isrc);
            chk($sformatf("v%0d ex_alu_pcsrc", i), ex_alu_pcsrc, e_psrc);
            chk($sformatf("v%0d ex_mem_write", i), ex_mem_write, e_mw);
            chk($sformatf("v%0d ex_mem_to_reg", i), ex_mem_to_reg, e_m2r);
        end

        // EX holds rd=26 (ALU op): forwarding build proceeds, otherwise ID stalls
        drive_id(1, 26, 0, 27, 1, 0, 32'h1, 32'h0, 0, 1);
        #1;
        chk("ex-dep id_stall", id_stall, FWD ? 1'b0 : 1'b1);
        tick();
        chk("ex-dep ex_valid", ex_valid, FWD ? 1'b1 : 1'b0);
        drive_id(1, 0, 9, 28, 1, 1, 32'h0, 32'h0, 0, 1);
        mem_reg_write = 1; mem_rd = 9;
        #1;
        chk("mem-dep id_stall", id_stall, FWD ? 1'b0 : 1'b1);
        id_rs2 = 0; mem_rd = 0;
        #1;
        chk("mem-x0 id_stall", id_stall, 0);
        mem_reg_write = 0;
        id_valid = 0;
        tick();

        // Forwarding priority on rs1=x5, rs2=x6
        drive_id(1, 5, 6, 8, 1, 1, 32'h10, 32'h60, 0, 1);
        tick();
        chk("fwd stored rdata1", ex_rdata1, 32'h10);
        id_valid = 0;
        mem_reg_write = 1; mem_rd = 5; mem_fwd_data = 32'h1234;
        wb_reg_write = 1; wb_rd = 5; wb_data = 32'h99;
        #1;
        chk("fwd mem-over-wb rdata1", ex_rdata1, FWD ? 32'h1234 : 32'h10);
        mem_rd = 0;
        #1;
        chk("fwd wb rdata1", ex_rdata1, FWD ? 32'h99 : 32'h10);
        wb_rd = 6;
        #1;
        chk("fwd none rdata1", ex_rdata1, 32'h10);
        chk("fwd wb rdata2", ex_rdata2, FWD ? 32'h99 : 32'h60);
        mem_reg_write = 0; wb_reg_write = 0;

        // x0 is never forwarded
        drive_id(1, 0, 0, 9, 1, 0, 32'h0, 32'h0, 0, 1);
        tick();
        mem_reg_write = 1; mem_rd = 0; mem_fwd_data = 32'hFFFF;
        wb_reg_write = 1; wb_rd = 0; wb_data = 32'hEEEE;
        #1;
        chk("x0 guard rdata1", ex_rdata1, 32'h0);
        mem_reg_write = 0; wb_reg_write = 0;

        // Operand refresh across a 3-cycle external hold
        drive_id(1, 3, 0, 10, 1, 0, 32'h3333, 32'h0, 0, 1);
        tick();
        id_valid = 0; stall_ext = 1;
        tick();
        wb_reg_write = 1; wb_rd = 3; wb_data = 32'hABCD;
        tick();
        wb_reg_write = 0;
        tick();
        stall_ext = 0;
        #1;
        chk("refresh rdata1", ex_rdata1, FWD ? 32'hABCD : 32'h3333);
        chk("refresh ex_valid", ex_valid, 1);
        chk("refresh ex_rd", ex_rd, 10);

        // Asynchronous reset mid-cycle with a valid instruction in ID
        drive_id(1, 1, 0, 12, 1, 0, 32'h77, 32'h0, 0, 1);
        id_pc = 32'h4444;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset ex_valid", ex_valid, 0);
        chk("async reset ex_pc", ex_pc, 0);
        chk("async reset ex_rdata1", ex_rdata1, 0);
        chk("async reset ex_rd", ex_rd, 0);
        chk("async reset ex_reg_write", ex_reg_write, 0);
        chk("async reset id_stall", id_stall, 0);
        tick();
        chk("in reset ex_valid", ex_valid, 0);
        #3;
        rst_n = 1'b1;
        tick();
        chk("post reset ex_valid", ex_valid, 1);
        chk("post reset ex_pc", ex_pc, 32'h4444);
        chk("post reset ex_rdata1", ex_rdata1, 32'h77);
        chk("post reset ex_rd", ex_rd, 12);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
